// File: rtl/fadd_acc_stage_if.sv
// Operand/result bus of the FP32 accumulate stage.
// master = product source and sum sink, slave = the accumulator.
interface fadd_acc_stage_if;
  logic [31:0] input_add;
  logic        input_add_stb;
  logic        s_input_add_ack;
  logic [31:0] z;
  logic        s_output_z_stb;

  modport master (
    output input_add, input_add_stb,
    input  s_input_add_ack, z, s_output_z_stb
  );

  modport slave (
    input  input_add, input_add_stb,
    output s_input_add_ack, z, s_output_z_stb
  );
endinterface

// File: rtl/fadd_acc_stage.sv
// FP32 running accumulator: z = acc + input_add, fixed 6-cycle latency.
// A one-deep skid register holds the next operand while the datapath is busy.
module fadd_acc_stage #(
  parameter logic [31:0] ACC_INIT = 32'h0000_0000,
  parameter int unsigned LATENCY  = 6
) (
  input  logic            clk,
  input  logic            rst,
  fadd_acc_stage_if.slave bus,
  input  logic            acc_clr,
  output logic            ovf,
  output logic [2:0]      state
);
  localparam int unsigned SIG_W = 24;          // mantissa with hidden bit
  localparam int unsigned EXT_W = SIG_W + 3;   // plus guard, round, sticky
  localparam int unsigned SUM_W = EXT_W + 1;   // plus carry-out
  localparam int unsigned EN_W  = 10;          // signed working exponent
  localparam logic [31:0] QNAN  = 32'hFFC0_0000;

  // put_z encoding equals the fixed operand-to-result latency
  typedef enum logic [2:0] {
    S_GET = 3'd0, S_UNPACK = 3'd1, S_ALIGN = 3'd2, S_ADD = 3'd3,
    S_NORM = 3'd4, S_ROUND = 3'd5, S_PUT_Z = 3'(LATENCY)
  } state_t;

  state_t st_q, st_d;
  logic        stb_q, stb_d, ack_q, ovf_q, skip_wr_q;
  logic        skid_full_q, skid_full_d, take, cap, drop;
  logic [31:0] skid_q, op_q, acc_q, z_q;

  logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic              spc_d, spc_q;
  logic [31:0]       spc_val_d, spc_val_q;
  logic              ua_s, ub_s;
  logic [7:0]        ua_e, ub_e;
  logic [SIG_W-1:0]  ua_m, ub_m;

  logic                 a_big, s_l, s_s;
  logic [7:0]           e_l, e_s, d;
  logic [SIG_W-1:0]     m_l, m_s;
  logic [2*EXT_W-1:0]   ext;
  logic [EXT_W-1:0]     ms_d, al_ml, al_ms;
  logic                 al_s, al_sub;
  logic [7:0]           al_e;

  logic [SUM_W-1:0]     sum_d, ad_sum;
  logic                 ad_s;
  logic [7:0]           ad_e;

  logic [4:0]             lzc;
  logic signed [EN_W-1:0] exp_ext, ne_d, ne_q, er;
  logic [EXT_W-1:0]       nm_d, nm_q;
  logic                   n_s, n_zero;

  logic             rup;
  logic [SIG_W:0]   mr;
  logic [22:0]      frac;
  logic [31:0]      res_d;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_q <= S_GET;
    else      st_q <= st_d;
  end

  always_comb begin
    st_d  = st_q;
    stb_d = 1'b0;
    case (st_q)
      S_GET:    if (skid_full_q) st_d = S_UNPACK;
      S_UNPACK: st_d = S_ALIGN;
      S_ALIGN:  st_d = S_ADD;
      S_ADD:    st_d = S_NORM;
      S_NORM:   st_d = S_ROUND;
      S_ROUND:  begin st_d = S_PUT_Z; stb_d = 1'b1; end
      S_PUT_Z:  st_d = S_GET;
      default:  st_d = S_GET;
    endcase
  end

  // a slot freed by get this edge can be refilled on the same edge
  assign take        = (st_q == S_GET) && skid_full_q;
  assign cap         = bus.input_add_stb && (!skid_full_q || take);
  assign drop        = bus.input_add_stb && !cap;
  assign skid_full_d = cap || (skid_full_q && !take);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_full_q <= 1'b0;
      skid_q      <= '0;
      ack_q       <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      skid_full_q <= skid_full_d;
      ack_q       <= !skid_full_d;
      ovf_q       <= drop || (ovf_q && !acc_clr);
      if (cap) skid_q <= bus.input_add;
    end
  end

  assign a_zero = (op_q[30:23] == 8'h00);
  assign a_inf  = (op_q[30:23] == 8'hFF) && (op_q[22:0] == 23'h0);
  assign a_nan  = (op_q[30:23] == 8'hFF) && (op_q[22:0] != 23'h0);
  assign b_zero = (acc_q[30:23] == 8'h00);
  assign b_inf  = (acc_q[30:23] == 8'hFF) && (acc_q[22:0] == 23'h0);
  assign b_nan  = (acc_q[30:23] == 8'hFF) && (acc_q[22:0] != 23'h0);

  // special operands resolve here and ride alongside the datapath
  always_comb begin
    spc_d     = 1'b1;
    spc_val_d = '0;
    if (a_nan || b_nan)                               spc_val_d = QNAN;
    else if (a_inf && b_inf && (op_q[31] != acc_q[31])) spc_val_d = QNAN;
    else if (a_inf)                                   spc_val_d = op_q;
    else if (b_inf)                                   spc_val_d = acc_q;
    else if (a_zero && b_zero) spc_val_d = {op_q[31] & acc_q[31], 31'h0};
    else if (a_zero)                                  spc_val_d = acc_q;
    else if (b_zero)                                  spc_val_d = op_q;
    else                                              spc_d = 1'b0;
  end

  // align: larger magnitude first, smaller shifted right with sticky
  always_comb begin
    a_big = {ua_e, ua_m} >= {ub_e, ub_m};
    s_l   = a_big ? ua_s : ub_s;
    s_s   = a_big ? ub_s : ua_s;
    e_l   = a_big ? ua_e : ub_e;
    e_s   = a_big ? ub_e : ua_e;
    m_l   = a_big ? ua_m : ub_m;
    m_s   = a_big ? ub_m : ua_m;
    d     = e_l - e_s;
    ext   = {m_s, 3'b000, EXT_W'(0)} >> d;
    if (d >= 8'(EXT_W)) ms_d = EXT_W'(1);
    else ms_d = {ext[2*EXT_W-1:EXT_W+1], ext[EXT_W] | (|ext[EXT_W-1:0])};
  end

  assign sum_d = al_sub ? ({1'b0, al_ml} - {1'b0, al_ms})
                        : ({1'b0, al_ml} + {1'b0, al_ms});

  always_comb begin
    lzc = 5'd0;
    for (int i = 0; i < int'(EXT_W); i++)
      if (ad_sum[i]) lzc = 5'(int'(EXT_W) - 1 - i);
    exp_ext = $signed({2'b00, ad_e});
    if (ad_sum[SUM_W-1]) begin
      nm_d = {ad_sum[SUM_W-1:2], ad_sum[1] | ad_sum[0]};
      ne_d = exp_ext + 10'sd1;
    end else begin
      nm_d = ad_sum[EXT_W-1:0] << lzc;
      ne_d = exp_ext - $signed({5'b00000, lzc});
    end
  end

  // round to nearest even, then saturate to inf or flush to zero
  always_comb begin
    rup  = nm_q[2] & (nm_q[1] | nm_q[0] | nm_q[3]);
    mr   = {1'b0, nm_q[EXT_W-1:3]} + 25'(rup);
    frac = mr[SIG_W] ? mr[SIG_W-1:1] : mr[SIG_W-2:0];
    er   = mr[SIG_W] ? ne_q + 10'sd1 : ne_q;
    res_d = {n_s, er[7:0], frac};
    if (spc_q)              res_d = spc_val_q;
    else if (n_zero)        res_d = 32'h0000_0000;
    else if (er >= 10'sd255) res_d = {n_s, 8'hFF, 23'h0};
    else if (er <= 10'sd0)   res_d = {n_s, 31'h0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q <= '0; acc_q <= ACC_INIT; z_q <= '0; stb_q <= 1'b0; skip_wr_q <= 1'b0;
      spc_q <= 1'b0; spc_val_q <= '0;
      ua_s <= 1'b0; ub_s <= 1'b0; ua_e <= '0; ub_e <= '0; ua_m <= '0; ub_m <= '0;
      al_s <= 1'b0; al_sub <= 1'b0; al_e <= '0; al_ml <= '0; al_ms <= '0;
      ad_sum <= '0; ad_s <= 1'b0; ad_e <= '0;
      nm_q <= '0; ne_q <= '0; n_s <= 1'b0; n_zero <= 1'b0;
    end else begin
      stb_q <= stb_d;
      if (take) begin
        op_q      <= skid_q;
        skip_wr_q <= 1'b0;
      end else if (acc_clr && (st_q != S_GET)) begin
        skip_wr_q <= 1'b1;
      end
      // a clear always wins; an operation that saw a clear mid-flight never writes back
      if (acc_clr) acc_q <= ACC_INIT;
      else if ((st_q == S_PUT_Z) && !skip_wr_q) acc_q <= z_q;
      if (st_q == S_UNPACK) begin
        spc_q <= spc_d; spc_val_q <= spc_val_d;
        ua_s <= op_q[31];  ua_e <= op_q[30:23];  ua_m <= {1'b1, op_q[22:0]};
        ub_s <= acc_q[31]; ub_e <= acc_q[30:23]; ub_m <= {1'b1, acc_q[22:0]};
      end
      if (st_q == S_ALIGN) begin
        al_s <= s_l; al_sub <= (s_l != s_s); al_e <= e_l;
        al_ml <= {m_l, 3'b000}; al_ms <= ms_d;
      end
      if (st_q == S_ADD) begin
        ad_sum <= sum_d; ad_s <= al_s; ad_e <= al_e;
      end
      if (st_q == S_NORM) begin
        nm_q <= nm_d; ne_q <= ne_d; n_s <= ad_s; n_zero <= (ad_sum == '0);
      end
      if (st_q == S_ROUND) z_q <= res_d;
    end
  end

  assign bus.s_input_add_ack = ack_q;
  assign bus.z               = z_q;
  assign bus.s_output_z_stb  = stb_q;
  assign ovf                 = ovf_q;
  assign state               = st_q;
endmodule

// File: doc/fadd_acc_stage.md
Name: fadd_acc_stage

Overview:
- Downstream consumer of the FP32 multiplier's product stream: accepts each product `z` (one-cycle valid pulse) and adds it into a running FP32 accumulator.
- Emits every updated sum with a one-cycle valid pulse.
- Forms the accumulate half of a multiply-accumulate path. Holds one pending operand in a skid register so back-to-back products are not lost.

Parameters:
- ACC_INIT, 32'h00000000, accumulator value after reset and after acc_clr.
- LATENCY, 6, fixed cycles from operand capture to s_output_z_stb (informational; design is built for 6).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- input_add  in  32  FP32 operand (multiplier product)
- input_add_stb  in  1  operand valid, one-cycle pulse, no back-pressure honoured by source
- s_input_add_ack  out  1  high when skid register empty (can accept)
- acc_clr  in  1  synchronous clear of accumulator to ACC_INIT
- z  out  32  updated accumulator value
- s_output_z_stb  out  1  z valid, one-cycle pulse
- ovf  out  1  sticky: operand dropped because skid register full; cleared by acc_clr or rst
- state  out  3  current FSM state (debug)

Behaviour:
- Reset (rst=0, asynchronous): state=get, z=0, s_output_z_stb=0, s_input_add_ack=1, ovf=0, acc=ACC_INIT, skid empty. Any in-flight operation is discarded and no stb follows release.
- Skid register captures input_add whenever input_add_stb=1 and the register is empty, in any state.
- If input_add_stb=1 and the register is full, the operand is dropped and ovf<=1.
- s_input_add_ack = skid empty (registered).
- FSM states: get(0), unpack(1), align(2), add(3), norm(4), round(5), put_z(6).
  - get: if skid full, move operand to datapath, mark skid empty, go unpack; else stay.
  - A pulse arriving in get with skid empty is captured that edge and consumed the next cycle.
- Fixed latency: s_output_z_stb high exactly 6 cycles after the cycle in which the operand leaves the skid (get->unpack edge counted as 1). Special cases carry a flag through all stages; they do not shortcut.
- unpack: split sign, exponent, and mantissa with hidden bit; apply special cases.
  - exp==0 (zero or subnormal) is treated as signed zero.
  - Either operand NaN -> 32'hFFC00000.
  - inf + (-inf) -> 32'hFFC00000.
  - inf + finite -> that inf.
  - zero + x -> x.
  - (-0)+(-0) -> 32'h80000000.
- align: swap so the larger magnitude is first. Right-shift the smaller mantissa by the exponent difference into 27 bits (24 + guard + round + sticky); bits shifted past sticky OR into sticky. A shift of 27 or more leaves sticky only.
- add: same signs add magnitudes, otherwise subtract smaller from larger; 28-bit result, sign of the larger.
- norm: on carry-out, shift right 1 (sticky preserved) and exp+1. Otherwise left-shift by leading-zero count and exp-lzc.
- round: round-to-nearest-even on guard/(round|sticky); a mantissa carry increments exp.
  - exp>=255 -> signed inf.
  - exp<=0 -> signed zero (flush).
  - Exact zero from cancellation -> +0.
- put_z: z<=result, acc<=result, s_output_z_stb<=1 for one cycle, go get. The stb is cleared in every other state.
- acc_clr=1: acc<=ACC_INIT and ovf<=0.
  - In get or put_z, the clear takes priority over the put_z write of acc.
  - An operation already past get still completes using the old acc and then does not write acc.
  - A clear coincident with the get->unpack transition applies first: the operand is added to ACC_INIT.
- Accumulator operand is sampled in unpack.

Test Plan:
1. Reset, feed 0x3F800000 then, after its stb, 0x40000000 -> z=0x3F800000 at +6 cycles, then z=0x40400000.
2. acc=0x40400000, feed 0xC0400000 -> z=0x00000000; feed 0x80000000 -> z=0x00000000.
3. acc=0x3F800000, feed 0x33800000 (tie) -> z=0x3F800000; feed 0x33800001 -> z=0x3F800001.
4. Specials and overflow:
   - Feed 0x7F800000 -> z=0x7F800000.
   - Feed 0xFF800000 -> z=0xFFC00000; then 0x3F800000 -> z=0xFFC00000.
   - acc_clr, then feed 0x7F7FFFFF twice -> z=0x7F7FFFFF, then z=0x7F800000.
5. Pulses on cycles t, t+1, t+2 while busy:
   - First pulse enters the datapath and the second is held with ack=0.
   - The third pulse sets ovf=1.
   - Exactly two stbs follow; acc_clr then clears ovf.
6. rst low during align -> z=0, stb=0, ack=1 immediately. After release there is no stb, and feeding 0x3F800000 gives z=0x3F800000.
